// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_pkg                                                     |
// | Description : Shared constants for the Harvard MIPS core: reset vector,    |
// |               opcode / funct / REGIMM encodings and the ALU operation enum.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI     = 6'h0F, OP_LW     = 6'h23, OP_SW    = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                         F_JR   = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21,
                         F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  // REGIMM rt codes; this core does not implement them, they decode as NOP
  localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01,
                         RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_regfile                                                 |
// | Description : 32x32 general purpose register file. Two combinational read  |
// |               ports, one write port at the rising clock edge, async reset. |
// |               $0 reads as zero and ignores writes.                         |
// | Ports       : clk_i, rst_i (async, active high)                            |
// |               rs_addr_i/rs_data_o, rt_addr_i/rt_data_o : read ports        |
// |               we_i, wr_addr_i, wr_data_i               : write port        |
// |               v0_o                                     : copy of $2        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wr_addr_i != 5'd0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs_data_o = (rs_addr_i == 5'd0) ? 32'h0 : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? 32'h0 : regs_q[rt_addr_i];
  assign v0_o      = regs_q[2];

endmodule
`default_nettype wire

// File: rtl/mips_cpu_harvard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_cpu_harvard                                             |
// | Description : Single-cycle Harvard MIPS-I subset core with one branch      |
// |               delay slot. Halts when the next fetch address is 0.          |
// | Ports       : clk, reset (async, active high), clk_enable (freeze when 0)  |
// |               active            : high while executing                     |
// |               register_v0       : copy of $2                               |
// |               instr_address/instr_readdata : instruction fetch (comb.)     |
// |               data_address/data_read/data_write/data_writedata/            |
// |               data_readdata     : data memory port (comb. read)            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_cpu_harvard
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  // Architectural state; tgt_q/pend_q carry a taken branch across its delay slot
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
  logic        pend_q, pend_d, active_q, active_d;
  logic        commit;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;

  assign opcode = instr_readdata[31:26];
  assign rs     = instr_readdata[25:21];
  assign rt     = instr_readdata[20:16];
  assign rd     = instr_readdata[15:11];
  assign shamt  = instr_readdata[10:6];
  assign funct  = instr_readdata[5:0];
  assign imm16  = instr_readdata[15:0];
  assign imm26  = instr_readdata[25:0];

  logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, pc_plus8;

  assign imm_sext = sext16(imm16);
  assign imm_zext = {16'h0, imm16};
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // State only advances on an enabled edge of a running, non-reset core
  assign commit = active_q & clk_enable & ~reset;

  // Decode
  alu_op_e     alu_op;
  logic        alu_b_imm, shift_var, wr_en, wr_link, mem_rd, mem_wr, jump;
  logic [31:0] imm_val, jump_tgt;
  logic [4:0]  wr_addr;

  always_comb begin
    alu_op    = ALU_ADD;
    alu_b_imm = 1'b0;
    imm_val   = imm_sext;
    shift_var = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = rd;
    wr_link   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    jump      = 1'b0;
    jump_tgt  = pc_plus4 + (imm_sext << 2);
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU: begin alu_op = ALU_ADD;  wr_en = 1'b1; end
          F_SUBU: begin alu_op = ALU_SUB;  wr_en = 1'b1; end
          F_AND:  begin alu_op = ALU_AND;  wr_en = 1'b1; end
          F_OR:   begin alu_op = ALU_OR;   wr_en = 1'b1; end
          F_XOR:  begin alu_op = ALU_XOR;  wr_en = 1'b1; end
          F_SLT:  begin alu_op = ALU_SLT;  wr_en = 1'b1; end
          F_SLTU: begin alu_op = ALU_SLTU; wr_en = 1'b1; end
          F_SLL:  begin alu_op = ALU_SLL;  wr_en = 1'b1; end
          F_SRL:  begin alu_op = ALU_SRL;  wr_en = 1'b1; end
          F_SRA:  begin alu_op = ALU_SRA;  wr_en = 1'b1; end
          F_SLLV: begin alu_op = ALU_SLL;  wr_en = 1'b1; shift_var = 1'b1; end
          F_SRLV: begin alu_op = ALU_SRL;  wr_en = 1'b1; shift_var = 1'b1; end
          F_SRAV: begin alu_op = ALU_SRA;  wr_en = 1'b1; shift_var = 1'b1; end
          F_JR:   begin jump = 1'b1; jump_tgt = rs_val; end
          F_JALR: begin
            jump     = 1'b1;
            jump_tgt = rs_val;
            wr_en    = 1'b1;
            wr_link  = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: ;
      OP_J: begin
        jump     = 1'b1;
        jump_tgt = {pc_plus4[31:28], imm26, 2'b00};
      end
      OP_JAL: begin
        jump     = 1'b1;
        jump_tgt = {pc_plus4[31:28], imm26, 2'b00};
        wr_en    = 1'b1;
        wr_addr  = 5'd31;
        wr_link  = 1'b1;
      end
      OP_BEQ:   jump = (rs_val == rt_val);
      OP_BNE:   jump = (rs_val != rt_val);
      OP_ADDIU: begin alu_op = ALU_ADD;  alu_b_imm = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b_imm = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b_imm = 1'b1; wr_en = 1'b1; wr_addr = rt; end
      OP_ANDI: begin
        alu_op = ALU_AND; alu_b_imm = 1'b1; imm_val = imm_zext; wr_en = 1'b1; wr_addr = rt;
      end
      OP_ORI: begin
        alu_op = ALU_OR;  alu_b_imm = 1'b1; imm_val = imm_zext; wr_en = 1'b1; wr_addr = rt;
      end
      OP_XORI: begin
        alu_op = ALU_XOR; alu_b_imm = 1'b1; imm_val = imm_zext; wr_en = 1'b1; wr_addr = rt;
      end
      OP_LUI: begin alu_op = ALU_LUI; wr_en = 1'b1; wr_addr = rt; end
      OP_LW: begin
        alu_op = ALU_ADD; alu_b_imm = 1'b1; mem_rd = 1'b1; wr_en = 1'b1; wr_addr = rt;
      end
      OP_SW: begin alu_op = ALU_ADD; alu_b_imm = 1'b1; mem_wr = 1'b1; end
      default: ;
    endcase
  end

  // ALU; shifts always operate on rt
  logic [31:0] alu_b, alu_y, wr_data;
  logic [4:0]  sh;

  assign alu_b = alu_b_imm ? imm_val : rt_val;
  assign sh    = shift_var ? rs_val[4:0] : shamt;

  always_comb begin
    alu_y = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_y = rs_val + alu_b;
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_XOR:  alu_y = rs_val ^ alu_b;
      ALU_SLT:  alu_y = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      ALU_SLTU: alu_y = {31'd0, (rs_val < alu_b)};
      ALU_SLL:  alu_y = rt_val << sh;
      ALU_SRL:  alu_y = rt_val >> sh;
      ALU_SRA:  alu_y = $unsigned($signed(rt_val) >>> sh);
      ALU_LUI:  alu_y = {imm16, 16'h0};
      default:  alu_y = 32'h0;
    endcase
  end

  assign wr_data = mem_rd ? data_readdata : (wr_link ? pc_plus8 : alu_y);

  mips_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (reset),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .rs_data_o (rs_val),
    .rt_data_o (rt_val),
    .we_i      (wr_en & commit),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .v0_o      (register_v0)
  );

  // Next state: a branch decided last cycle redirects the fetch after its slot
  always_comb begin
    pc_d     = pend_q ? tgt_q : pc_plus4;
    pend_d   = jump;
    tgt_d    = jump_tgt;
    active_d = (pc_d != 32'h0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      tgt_q    <= 32'h0;
      pend_q   <= 1'b0;
      active_q <= 1'b1;
    end else if (commit) begin
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc_q;
  assign data_address   = {alu_y[31:2], 2'b00};
  assign data_read      = mem_rd & active_q & ~reset;
  assign data_write     = mem_wr & commit;
  assign data_writedata = rt_val;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_harvard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_cpu_harvard                                          |
// | Description : Self-checking bench for mips_cpu_harvard: directed program   |
// |               table, freeze / reset corner sequences and random ALU        |
// |               programs compared against an instruction-level model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips_cpu_harvard;

  localparam logic [31:0] RV  = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] JR0 = 32'h00000008;
  localparam int NV = 11;

  logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b1;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] mregs [32];
  logic [31:0] off;

  int n_tests = 0, n_fail = 0;
  int wr_cycles = 0, both_cycles = 0;

  mips_cpu_harvard #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  // Outside the program window the ROM returns ADDIU $2,$2,1 so a core that
  // keeps running after halt visibly corrupts $2.
  assign off            = instr_address - RV;
  assign instr_readdata = (off < 32'd256) ? imem[off[7:2]] : 32'h24420001;
  assign data_readdata  = dmem[data_address[7:2]];

  always @(posedge clk) if (data_write) dmem[data_address[7:2]] <= data_writedata;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_write) wr_cycles++;
      if (data_write && data_read) both_cycles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  task automatic do_reset();
    clk_enable = 1'b1;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (active === 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Instruction-level reference model of the register-writing subset
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] a, b, r, sx, zx;
    int          dst;
    bit          wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sa = ins[10:6];  fn = ins[5:0];
    a  = mregs[rs];  b  = mregs[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    r  = 32'h0; wr = 1'b1; dst = int'(rd);
    if (op == 6'h00) begin
      case (fn)
        6'h21: r = a + b;
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: r = (a < b) ? 32'd1 : 32'd0;
        6'h00: r = b << sa;
        6'h02: r = b >> sa;
        6'h03: r = $unsigned($signed(b) >>> sa);
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = $unsigned($signed(b) >>> a[4:0]);
        default: wr = 1'b0;
      endcase
    end else begin
      dst = int'(rt);
      case (op)
        6'h09: r = a + sx;
        6'h0A: r = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
        6'h0B: r = (a < sx) ? 32'd1 : 32'd0;
        6'h0C: r = a & zx;
        6'h0D: r = a | zx;
        6'h0E: r = a ^ zx;
        6'h0F: r = {ins[15:0], 16'h0};
        default: wr = 1'b0;
      endcase
    end
    if (wr && dst != 0) mregs[dst] = r;
  endtask

  function automatic logic [31:0] gen_rand();
    logic [4:0]  s, t, d, sa;
    logic [15:0] im;
    s  = 5'($urandom_range(0, 4));
    t  = 5'($urandom_range(0, 4));
    d  = 5'($urandom_range(0, 4));
    sa = 5'($urandom_range(0, 31));
    im = 16'($urandom);
    case ($urandom_range(0, 19))
      0:  return enc_r(s, t, d, 5'd0, 6'h21);
      1:  return enc_r(s, t, d, 5'd0, 6'h23);
      2:  return enc_r(s, t, d, 5'd0, 6'h24);
      3:  return enc_r(s, t, d, 5'd0, 6'h25);
      4:  return enc_r(s, t, d, 5'd0, 6'h26);
      5:  return enc_r(s, t, d, 5'd0, 6'h2A);
      6:  return enc_r(s, t, d, 5'd0, 6'h2B);
      7:  return enc_r(5'd0, t, d, sa, 6'h00);
      8:  return enc_r(5'd0, t, d, sa, 6'h02);
      9:  return enc_r(5'd0, t, d, sa, 6'h03);
      10: return enc_r(s, t, d, 5'd0, 6'h04);
      11: return enc_r(s, t, d, 5'd0, 6'h06);
      12: return enc_r(s, t, d, 5'd0, 6'h07);
      13: return enc_i(6'h09, s, t, im);
      14: return enc_i(6'h0C, s, t, im);
      15: return enc_i(6'h0D, s, t, im);
      16: return enc_i(6'h0E, s, t, im);
      17: return enc_i(6'h0A, s, t, im);
      18: return enc_i(6'h0B, s, t, im);
      default: return enc_i(6'h0F, 5'd0, t, im);
    endcase
  endfunction

  typedef struct {
    logic [0:9][31:0] prog;
    logic [31:0]      exp_v0;
    int               max_cyc;
    int               exp_wr;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int cyc, base;
    logic [31:0] ins;

    // ---------------- directed program table ----------------
    vecs[0].prog = '{enc_i(6'h09, 5'd0, 5'd2, 16'd5), JR0, NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP};
    vecs[0].exp_v0 = 32'h00000005; vecs[0].max_cyc = 4; vecs[0].exp_wr = 0;

    vecs[1].prog = '{enc_i(6'h09, 5'd0, 5'd3, 16'h1234), enc_i(6'h2B, 5'd0, 5'd3, 16'd4),
                     enc_i(6'h23, 5'd0, 5'd2, 16'd4), JR0, NOP, NOP, NOP, NOP, NOP, NOP};
    vecs[1].exp_v0 = 32'h00001234; vecs[1].max_cyc = 6; vecs[1].exp_wr = 1;

    vecs[2].prog = '{enc_i(6'h04, 5'd0, 5'd0, 16'd2), enc_i(6'h09, 5'd0, 5'd2, 16'd1),
                     enc_i(6'h09, 5'd2, 5'd2, 16'd8), enc_i(6'h09, 5'd2, 5'd2, 16'd2),
                     JR0, NOP, NOP, NOP, NOP, NOP};
    vecs[2].exp_v0 = 32'h00000003; vecs[2].max_cyc = 6; vecs[2].exp_wr = 0;

    vecs[3].prog = '{enc_i(6'h0F, 5'd0, 5'd2, 16'h8000), enc_r(5'd0, 5'd2, 5'd2, 5'd4, 6'h03),
                     JR0, NOP, NOP, NOP, NOP, NOP, NOP, NOP};
    vecs[3].exp_v0 = 32'hF8000000; vecs[3].max_cyc = 5; vecs[3].exp_wr = 0;

    vecs[4].prog = '{enc_i(6'h0F, 5'd0, 5'd2, 16'h8000), enc_r(5'd0, 5'd2, 5'd2, 5'd4, 6'h03),
                     enc_r(5'd0, 5'd2, 5'd2, 5'd0, 6'h2B), JR0, NOP, NOP, NOP, NOP, NOP, NOP};
    vecs[4].exp_v0 = 32'h00000001; vecs[4].max_cyc = 6; vecs[4].exp_wr = 0;

    // JAL at word 0 to word 4; $31 = BFC00008
    vecs[5].prog = '{enc_j(6'h03, RV + 32'h10), NOP, enc_i(6'h09, 5'd0, 5'd2, 16'd99), NOP,
                     enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21), JR0, NOP, NOP, NOP, NOP};
    vecs[5].exp_v0 = 32'hBFC00008; vecs[5].max_cyc = 6; vecs[5].exp_wr = 0;

    // JALR $4,$3 at word 2 to word 6; $4 = BFC00010
    vecs[6].prog = '{enc_i(6'h0F, 5'd0, 5'd3, 16'hBFC0), enc_i(6'h0D, 5'd3, 5'd3, 16'h0018),
                     enc_r(5'd3, 5'd0, 5'd4, 5'd0, 6'h09), NOP, enc_i(6'h09, 5'd0, 5'd2, 16'd1),
                     NOP, enc_r(5'd4, 5'd0, 5'd2, 5'd0, 6'h21), JR0, NOP, NOP};
    vecs[6].exp_v0 = 32'hBFC00010; vecs[6].max_cyc = 8; vecs[6].exp_wr = 0;

    vecs[7].prog = '{enc_i(6'h09, 5'd0, 5'd2, 16'd7), enc_i(6'h05, 5'd2, 5'd2, 16'd3),
                     enc_i(6'h09, 5'd2, 5'd2, 16'd1), enc_i(6'h09, 5'd2, 5'd2, 16'd1),
                     JR0, NOP, NOP, NOP, NOP, NOP};
    vecs[7].exp_v0 = 32'h00000009; vecs[7].max_cyc = 7; vecs[7].exp_wr = 0;

    vecs[8].prog = '{enc_i(6'h09, 5'd0, 5'd3, 16'hFFFF), enc_i(6'h0A, 5'd3, 5'd4, 16'h0000),
                     enc_i(6'h0B, 5'd3, 5'd5, 16'hFFFF), enc_i(6'h0C, 5'd3, 5'd6, 16'hFFFF),
                     enc_r(5'd4, 5'd6, 5'd2, 5'd0, 6'h21), enc_r(5'd2, 5'd5, 5'd2, 5'd0, 6'h21),
                     JR0, NOP, NOP, NOP};
    vecs[8].exp_v0 = 32'h00010000; vecs[8].max_cyc = 9; vecs[8].exp_wr = 0;

    vecs[9].prog = '{enc_i(6'h0D, 5'd0, 5'd3, 16'h0024), enc_i(6'h0F, 5'd0, 5'd4, 16'h8000),
                     enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h07), enc_r(5'd3, 5'd4, 5'd6, 5'd0, 6'h06),
                     enc_r(5'd5, 5'd6, 5'd2, 5'd0, 6'h23), enc_r(5'd0, 5'd2, 5'd2, 5'd0, 6'h23),
                     JR0, NOP, NOP, NOP};
    vecs[9].exp_v0 = 32'h10000000; vecs[9].max_cyc = 9; vecs[9].exp_wr = 0;

    vecs[10].prog = '{enc_i(6'h09, 5'd0, 5'd0, 16'd5), enc_i(6'h09, 5'd0, 5'd2, 16'd3),
                      enc_r(5'd2, 5'd0, 5'd2, 5'd0, 6'h21), enc_i(6'h0E, 5'd2, 5'd2, 16'h8001),
                      JR0, NOP, NOP, NOP, NOP, NOP};
    vecs[10].exp_v0 = 32'h00008002; vecs[10].max_cyc = 7; vecs[10].exp_wr = 0;

    // ---------------- reset state (store/load presented during reset) ----------------
    clear_imem();
    imem[0] = enc_i(6'h2B, 5'd0, 5'd0, 16'd0);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_pc", instr_address, RV);
    check("reset_active", {31'd0, active}, 32'd1);
    check("reset_v0", register_v0, 32'h0);
    check("reset_dwrite", {31'd0, data_write}, 32'd0);
    imem[0] = enc_i(6'h23, 5'd0, 5'd2, 16'd0);
    #1;
    check("reset_dread", {31'd0, data_read}, 32'd0);

    // ---------------- table-driven programs ----------------
    for (int v = 0; v < NV; v++) begin
      clear_imem();
      for (int i = 0; i < 10; i++) imem[i] = vecs[v].prog[i];
      do_reset();
      base = wr_cycles;
      run_to_halt(cyc);
      check($sformatf("vec%0d_v0", v), register_v0, vecs[v].exp_v0);
      check($sformatf("vec%0d_halted", v), {31'd0, active}, 32'd0);
      check($sformatf("vec%0d_cycles_le_%0d", v, vecs[v].max_cyc),
            {31'd0, (cyc <= vecs[v].max_cyc)}, 32'd1);
      check($sformatf("vec%0d_write_cycles", v), 32'(wr_cycles - base), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr != 0) check("vec_store_mem", dmem[1], 32'h00001234);
      repeat (3) begin
        @(posedge clk); #1;
      end
      check($sformatf("vec%0d_halt_pc_frozen", v), instr_address, 32'h0);
      check($sformatf("vec%0d_halt_v0_frozen", v), register_v0, vecs[v].exp_v0);
      check($sformatf("vec%0d_halt_strobes", v), {30'd0, data_read, data_write}, 32'd0);
    end

    // ---------------- freeze with a store pending ----------------
    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd8);
    imem[2] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    imem[4] = JR0;
    imem[5] = NOP;
    do_reset();
    @(posedge clk); #1;
    @(negedge clk) clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("freeze%0d_pc", k), instr_address, RV + 32'd4);
      check($sformatf("freeze%0d_v0", k), register_v0, 32'h1);
      check($sformatf("freeze%0d_dwrite", k), {31'd0, data_write}, 32'd0);
    end
    @(negedge clk) clk_enable = 1'b1;
    run_to_halt(cyc);
    check("freeze_final_v0", register_v0, 32'h3);
    check("freeze_store_mem", dmem[2], 32'h1);

    // ---------------- reset during a pending branch ----------------
    clear_imem();
    for (int i = 0; i < 10; i++) imem[i] = vecs[2].prog[i];
    do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midreset_pc", instr_address, RV);
    check("midreset_active", {31'd0, active}, 32'd1);
    @(negedge clk) reset = 1'b0;
    run_to_halt(cyc);
    check("midreset_final_v0", register_v0, 32'h3);

    // ---------------- random ALU programs vs model ----------------
    for (int p = 0; p < 3; p++) begin
      clear_imem();
      for (int i = 0; i < 24; i++) imem[i] = gen_rand();
      imem[24] = enc_r(5'd1, 5'd0, 5'd2, 5'd0, 6'h25);
      imem[25] = enc_r(5'd3, 5'd0, 5'd2, 5'd0, 6'h25);
      imem[26] = enc_r(5'd4, 5'd0, 5'd2, 5'd0, 6'h25);
      imem[27] = JR0;
      imem[28] = NOP;
      for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
      do_reset();
      for (int k = 0; k < 27; k++) begin
        ins = imem[k];
        @(posedge clk); #1;
        model_exec(ins);
        check($sformatf("rand%0d_i%0d_%08h", p, k, ins), register_v0, mregs[2]);
      end
      repeat (2) begin
        @(posedge clk); #1;
      end
      check($sformatf("rand%0d_halted", p), {31'd0, active}, 32'd0);
    end

    check("read_write_exclusive", 32'(both_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_cpu_harvard.md
MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 Parameter: RESET_VECTOR, 32'hBFC00000, first instruction fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 active  out  1  high while executing; low once halted.
REQ-005 register_v0  out  32  continuous copy of GPR $2.
REQ-006 clk_enable  in  1  low = freeze all state (PC, registers, active, halt status).
REQ-007 instr_address  out  32  byte address of current instruction (the PC).
REQ-008 instr_readdata  in  32  instruction word at instr_address, combinational, same cycle.
REQ-009 data_address  out  32  word-aligned byte address for loads/stores.
REQ-010 data_write  out  1  store strobe; memory writes data_writedata at the rising edge.
REQ-011 data_read  out  1  load strobe; data_readdata valid combinationally in the same cycle.
REQ-012 data_writedata  out  32  store data (rt value).
REQ-013 data_readdata  in  32  load data.

Function
REQ-014 Single-cycle Harvard core: one instruction fetched, executed and retired per enabled clock edge.
REQ-015 Supported: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-016 Unsupported opcodes SHALL execute as NOP.
REQ-017 Arithmetic is 32-bit modulo 2^32, no overflow traps.
REQ-018 ADDIU/SLTI/SLTIU, LW/SW offsets and branch offsets sign-extend imm16; ANDI/ORI/XORI zero-extend.
REQ-019 LUI writes {imm16, 16'h0}.
REQ-020 SLT/SLTI compare signed; SLTU/SLTIU compare unsigned after extension; result is 0 or 1.
REQ-021 Shifts use shamt (immediate forms) or rs[4:0] (variable forms); SRA/SRAV replicate bit 31.
REQ-022 $0 always reads 0; writes to it are discarded.
REQ-023 Register file reads are combinational; the single write port writes at the rising edge.
REQ-024 LW: data_address = rs + sext(imm), data_read=1, rt <= data_readdata.
REQ-025 SW: data_address = rs + sext(imm), data_write=1, data_writedata = rt.
REQ-026 data_read and data_write are never high together; both are 0 for all other instructions and while inactive.
REQ-027 Branches/jumps have one delay slot: the instruction at PC+4 always executes, then control transfers.
REQ-028 Branch target = PC+4 + (sext(imm)<<2).
REQ-029 J/JAL target = {PC+4[31:28], imm26, 2'b00}.
REQ-030 JAL writes PC+8 to $31; JALR writes PC+8 to rd.
REQ-031 Branch/jump in a delay slot: behaviour undefined, no check required.
REQ-032 Halt: when the next PC to fetch equals 32'h00000000, active goes low at that edge.
REQ-033 Halt: after active goes low, PC, registers and memory strobes stay frozen until reset.
REQ-034 Example halt sequence: JR $0 plus its delay slot completes, then active=0.
REQ-035 clk_enable=0: no register, PC or active change; data_write SHALL be 0.

Reset
REQ-036 While reset=1: PC=RESET_VECTOR, delay-slot/branch-pending state cleared, active=1, all GPRs=0 (register_v0=0), data_read=data_write=0.
REQ-037 Reset asserted mid-execution SHALL abort immediately; a pending branch is discarded.

Structure
REQ-038 Shared package mips_pkg holds opcode, funct and REGIMM constants, the RESET_VECTOR default, and the ALU-op enum.
REQ-039 One sub-module, mips_regfile: 32x32, two async read ports, one sync write port, async reset, v0 tap output.
REQ-040 instruction_memory (ROM, hex-file init, combinational read) and data_memory (RAM, sync write, combinational read) are bench-side models outside this block.

Verification
REQ-041 Reset pulse -> instr_address=BFC00000, active=1, register_v0=0.
REQ-042 ADDIU $2,$0,5; JR $0; NOP -> register_v0=00000005; active=0 within 4 cycles of reset release.
REQ-043 Store/load: ADDIU $3,$0,0x1234; SW $3,4($0); LW $2,4($0) -> register_v0=00001234; data_write high exactly one cycle.
REQ-044 Delay slot: BEQ $0,$0,+2; ADDIU $2,$0,1 (slot); ADDIU $2,$2,8 (skipped); ADDIU $2,$2,2 (target) -> register_v0=00000003.
REQ-045 Arithmetic edges: LUI $2,0x8000; SRA $2,$2,4 -> F8000000; SLTU $2,$0,$2 -> 00000001.
REQ-046 Freeze: clk_enable=0 for 3 cycles mid-program -> instr_address and register_v0 unchanged; execution resumes afterwards with the same final v0.
